// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-Lite address/data arbiter: CPU (M0) owns the bus by default,
// a loader (M1) borrows it on request; an interrupted M0 transfer is replayed.
module mfp_ahb_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] m0_HADDR,
  input  logic [31:0] m0_HWDATA,
  input  logic [1:0]  m0_HTRANS,
  input  logic        m0_HWRITE,
  input  logic [2:0]  m0_HSIZE,
  output logic        m0_HREADY,
  output logic [31:0] m0_HRDATA,
  input  logic        m1_req,
  output logic        m1_gnt,
  input  logic [31:0] m1_HADDR,
  input  logic [31:0] m1_HWDATA,
  input  logic [1:0]  m1_HTRANS,
  input  logic        m1_HWRITE,
  input  logic [2:0]  m1_HSIZE,
  output logic        m1_HREADY,
  output logic [31:0] m1_HRDATA,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic [1:0] {OWN_M0, OWN_M1, REPLAY} state_t;
  typedef enum logic [1:0] {DP_NONE, DP_M0, DP_M1} dp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } ap_t;

  state_t state, state_nxt;
  dp_t    dp_own, dp_nxt, fwd_src;
  ap_t    m0_ap, m1_ap, fwd, pend, pend_nxt;
  logic   pend_v, pend_v_nxt;
  logic   m0_turn, m0_turn_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic   hold_hit, m0_yield;

  assign m0_ap = '{addr: m0_HADDR, trans: m0_HTRANS, write: m0_HWRITE, size: m0_HSIZE};
  assign m1_ap = '{addr: m1_HADDR, trans: m1_HTRANS, write: m1_HWRITE, size: m1_HSIZE};

  assign hold_hit = (cnt >= HOLD_LIM);
  assign m1_gnt   = (state == OWN_M1) && !hold_hit;
  // M0 gives up its slot on a handover; its transfer is parked in pend instead
  assign m0_yield = (state == OWN_M0) && m1_req && !m0_turn;

  always_comb begin
    fwd     = m0_ap;
    fwd_src = DP_M0;
    case (state)
      OWN_M0: if (m0_yield) fwd.trans = TR_IDLE;
      OWN_M1: begin
        fwd     = m1_ap;
        fwd_src = DP_M1;
        if (!m1_gnt) fwd.trans = TR_IDLE;
      end
      REPLAY: fwd = pend;
      default: fwd = m0_ap;
    endcase
  end

  assign HADDR  = fwd.addr;
  assign HTRANS = fwd.trans;
  assign HWRITE = fwd.write;
  assign HSIZE  = fwd.size;
  assign HWDATA = (dp_own == DP_M1) ? m1_HWDATA : m0_HWDATA;

  assign m0_HRDATA = HRDATA;
  assign m1_HRDATA = HRDATA;

  // M0 thinks a parked transfer was accepted, so its data phase stalls until replayed
  always_comb begin
    if (pend_v)
      m0_HREADY = 1'b0;
    else if (dp_own == DP_M0 || state == OWN_M0)
      m0_HREADY = HREADY;
    else
      m0_HREADY = !m0_HTRANS[1];
  end

  always_comb begin
    if (dp_own == DP_M1)
      m1_HREADY = HREADY;
    else if (m1_HTRANS[1])
      m1_HREADY = m1_gnt ? HREADY : 1'b0;
    else
      m1_HREADY = 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    dp_nxt      = dp_own;
    pend_nxt    = pend;
    pend_v_nxt  = pend_v;
    cnt_nxt     = cnt;
    m0_turn_nxt = m0_turn;
    if (HREADY) begin
      dp_nxt = fwd.trans[1] ? fwd_src : DP_NONE;
      case (state)
        OWN_M0: begin
          if (m0_turn) begin
            m0_turn_nxt = 1'b0;
          end else if (m1_req) begin
            state_nxt = OWN_M1;
            if (m0_HTRANS[1]) begin
              pend_nxt   = m0_ap;
              pend_v_nxt = 1'b1;
            end
          end
        end
        OWN_M1: begin
          if (m1_gnt && m1_HTRANS[1]) cnt_nxt = cnt + 8'd1;
          // leave only between granted M1 transfers
          if (!fwd.trans[1] && (!m1_req || hold_hit)) begin
            state_nxt   = pend_v ? REPLAY : OWN_M0;
            cnt_nxt     = 8'd0;
            m0_turn_nxt = hold_hit && !pend_v;
          end
        end
        REPLAY: begin
          state_nxt  = OWN_M0;
          pend_v_nxt = 1'b0;
        end
        default: state_nxt = OWN_M0;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= OWN_M0;
      dp_own  <= DP_NONE;
      pend    <= '0;
      pend_v  <= 1'b0;
      cnt     <= 8'd0;
      m0_turn <= 1'b0;
    end else begin
      state   <= state_nxt;
      dp_own  <= dp_nxt;
      pend    <= pend_nxt;
      pend_v  <= pend_v_nxt;
      cnt     <= cnt_nxt;
      m0_turn <= m0_turn_nxt;
    end
  end

endmodule

// File: doc/mfp_ahb_arbiter.md
MFP_AHB_ARBITER -- requirements
Module: mfp_ahb_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, sets the maximum number of consecutive M1 address phases per grant (range 1-255).
REQ-002 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-003 HRESET  in  1  asynchronous, active-high reset.
REQ-004 m0_HADDR/m0_HWDATA  in  32 each  CPU (M0) address and write data.
REQ-005 m0_HTRANS  in  2, m0_HWRITE  in  1, m0_HSIZE  in  3  M0 control.
REQ-006 m0_HREADY  out  1, m0_HRDATA  out  32  M0 ready and read data.
REQ-007 m1_req  in  1  loader/secondary master bus request.
REQ-008 m1_gnt  out  1  M1 owns the address bus.
REQ-009 m1_HADDR/m1_HWDATA  in  32, m1_HTRANS  in  2, m1_HWRITE  in  1, m1_HSIZE  in  3  M1 bus signals.
REQ-010 m1_HREADY  out  1, m1_HRDATA  out  32  M1 ready and read data.
REQ-011 HADDR/HWDATA  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3  shared slave-side bus.
REQ-012 HREADY  in  1, HRDATA  in  32  slave-side response.

Function
REQ-013 States SHALL be OWN_M0, OWN_M1, and REPLAY; address-phase mux SHALL select M0 in OWN_M0, M1 in OWN_M1, and the pending register in REPLAY.
REQ-014 State transitions and the data-phase owner (dp_own: NONE/M0/M1) SHALL update only on edges where HREADY=1.
REQ-015 dp_own SHALL take the address-phase source when the forwarded HTRANS is NONSEQ/SEQ; otherwise NONE.
REQ-016 HWDATA SHALL come from the dp_own master (M0 for NONE); HRDATA SHALL fan out unchanged to both masters.
REQ-017 OWN_M0->OWN_M1 SHALL occur when m1_req=1 and HREADY=1; if m0_HTRANS is NONSEQ/SEQ on that edge, the arbiter SHALL capture m0 HADDR/HWRITE/HSIZE/HTRANS into a pending register and set pend_v.
REQ-018 m0_HREADY SHALL be HREADY when dp_own=M0 or the M0 address is being forwarded; SHALL be 0 while pend_v=1 and the replayed transfer has not completed its data phase; otherwise 1.
REQ-019 m1_gnt SHALL be 1 in OWN_M1 while the grant counter is below HOLD_MAX; the counter SHALL increment on each accepted M1 NONSEQ/SEQ address phase.
REQ-020 m1_HREADY SHALL be HREADY when dp_own=M1, 1 when M1 is idle, and 0 for any M1 NONSEQ/SEQ presented without m1_gnt.
REQ-021 OWN_M1 SHALL exit on HREADY=1 with m1_HTRANS=IDLE and (m1_req=0 or counter=HOLD_MAX); the next state SHALL be REPLAY if pend_v=1, else OWN_M0; the counter SHALL clear on exit.
REQ-022 REPLAY SHALL last exactly one accepted address phase; pend_v SHALL clear when it is accepted; the next state SHALL be OWN_M0 with dp_own=M0.
REQ-023 m1_req=1 during REPLAY SHALL NOT preempt the replay; re-grant SHALL occur no earlier than the first OWN_M0 cycle.
REQ-024 Simultaneous m1_req rise and HREADY=0 SHALL defer the handover until HREADY=1.
REQ-025 With HOLD_MAX reached and m1_req held high, the arbiter SHALL pass through OWN_M0 for at least one M0 address phase before re-granting M1.
REQ-026 The block SHALL insert zero latency in OWN_M0 with m1_req=0; the slave bus SHALL equal M0 combinationally.

Reset
REQ-027 HRESET=1 SHALL force state OWN_M0, dp_own=NONE, pend_v=0, counter=0, m1_gnt=0, and m0_HREADY=m1_HREADY=1 (HREADY assumed 1), independent of HCLK.
REQ-028 Reset asserted mid-transfer SHALL discard any pending M0 transfer; no replay SHALL occur after reset release.

Verification
REQ-029 m1_req=0, M0 read 0x1fc000cc, HREADY=1 -> HADDR=0x1fc000cc in the same cycle; m0_HRDATA=HRDATA one cycle later; m1_gnt=0 throughout.
REQ-030 M0 NONSEQ 0x00000254 on the edge m1_req rises -> pend_v=1, m1_gnt=1 next cycle; three M1 writes to 0x1f800000+ forwarded; m1_req drops -> REPLAY drives HADDR=0x00000254; m0_HREADY=0 until that data phase ends.
REQ-031 HOLD_MAX=4, m1_req held high -> m1_gnt drops after 4 accepted transfers; at least one M0 transfer is forwarded; m1_gnt reasserts.
REQ-032 HREADY held 0 for 3 cycles when m1_req rises -> no state change until HREADY=1; m0 data phase completes with m0_HREADY=1 on that cycle.
REQ-033 HRESET pulsed while in OWN_M1 with pend_v=1 -> OWN_M0, pend_v=0, m1_gnt=0 immediately; first post-reset HADDR equals live m0_HADDR.
REQ-034 M1 drives NONSEQ with m1_gnt=0 -> m1_HREADY=0, HTRANS reflects M0 only, no M1 write reaches the slave.
